fir_axil_slave_regs: RTL and testbench

//   AXI4-Lite slave register file that acts as the responder for the FIR_Filter
//   S00_AXI control port.
//   - Accepts single-beat writes and reads from the PS/VIP master.
//   - Holds NUM_REGS 32-bit control/coefficient registers and drives them to the
//     FIR datapath.
//   - Pulses a per-register strobe on every committed write.
//

---
 rtl/fir_axil_slave_regs_if.sv | 43 ++++
 rtl/fir_axil_slave_regs.sv | 173 +++++++++++++++++
 tb/tb_fir_axil_slave_regs.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_axil_slave_regs_if.sv
// AXI4-Lite bus bundle for the FIR filter control port.
// Parameters:
//   ADDR_W  byte address width
//   DATA_W  data bus width (the register file only supports 32)
// Modports:
//   master  the PS/VIP side. It drives the addresses, data and valids, and the B/R readies.
//   slave   the register file side. It drives the AW/W/AR readies and the B/R responses.
interface fir_axil_slave_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/fir_axil_slave_regs.sv
// AXI4-Lite slave register file that serves the FIR_Filter S00_AXI control port.
// The AW and W beats are captured independently. They commit together into one of
// NUM_REGS 32-bit registers, and only one write can be outstanding. Reads return
// one cycle after the AR handshake. Each committed write pulses that register's
// strobe for one cycle.
// Ports:
//   ACLK            clock; all logic runs on its rising edge
//   ARESET          asynchronous, active-high reset
//   s_axi           AXI4-Lite slave port (fir_axil_slave_regs_if.slave)
//   regs_o          flattened register contents; register k is at [k*32 +: 32]
//   reg_wr_pulse_o  one-cycle strobe per register, raised when its write commits
module fir_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    fir_axil_slave_regs_if.slave                s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                 reg_wr_pulse_o
);
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Write holding state. AW and W can arrive in either order.
    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bvalid_q;
    resp_e             bresp_q;
    logic [NUM_REGS-1:0] pulse_q;

    // Read response state
    logic              rvalid_q;
    resp_e             rresp_q;
    logic [DATA_W-1:0] rdata_q;

    logic aw_fire, w_fire, ar_fire, commit;
    logic [IDX_W-1:0] ar_idx;

    assign s_axi.awready = !ARESET && !aw_held && !bvalid_q;
    assign s_axi.wready  = !ARESET && !w_held  && !bvalid_q;
    assign s_axi.arready = !ARESET && !rvalid_q;

    assign aw_fire = s_axi.awvalid && s_axi.awready;
    assign w_fire  = s_axi.wvalid  && s_axi.wready;
    assign ar_fire = s_axi.arvalid && s_axi.arready;
    assign commit  = aw_held && w_held && !bvalid_q;
    assign ar_idx  = s_axi.araddr[ADDR_W-1:2];

    // The protection bits and the byte offset within a word have no effect.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Decode. An index with no matching register leaves wr_sel empty and rd_hit
    // low, which selects the SLVERR response.
    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   rd_word;
    logic                rd_hit;

    // NOTE: every output of this block gets a default before the loop, so no
    //       path leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (aw_idx_q == IDX_W'(k)) begin
                wr_sel[k] = 1'b1;
            end
            if (ar_idx == IDX_W'(k)) begin
                rd_word = regs_q[k];
                rd_hit  = 1'b1;
            end
        end
    end

    // Write channel control
    // NOTE: sequential state uses non-blocking assignments, so every flop in this
    //       block samples the values from before the edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            pulse_q  <= '0;
        end else begin
            pulse_q <= '0;
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s_axi.awaddr[ADDR_W-1:2];
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
                pulse_q  <= wr_sel;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register array with byte-lane merge
    // NOTE: the register array is reset on purpose, because the FIR datapath must
    //       see zero coefficients after reset. It is a small flop bank, not RAM.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_sel[k]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_q[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel. rd_word samples regs_q before the edge, so a read that lands
    // on the same edge as a write commit returns the old contents.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_word;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign reg_wr_pulse_o = pulse_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end
endmodule

// File: tb/tb_fir_axil_slave_regs.sv
// Self-checking bench for fir_axil_slave_regs. It uses ADDR_W = 5 and NUM_REGS = 4,
// so addresses 0x10 and above decode to missing registers. Expected responses
// are queued when a transaction is issued. They are popped and compared when the
// response comes back.
module tb_fir_axil_slave_regs;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 4;
    localparam int BUDGET   = 40;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic [NUM_REGS-1:0]        reg_wr_pulse_o;

    fir_axil_slave_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

    fir_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(DATA_W),
        .C_S_AXI_ADDR_WIDTH(ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .s_axi(s_axi),
        .regs_o(regs_o),
        .reg_wr_pulse_o(reg_wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [NUM_REGS];
    int          pulse_cnt [NUM_REGS];
    int          n_pass  = 0;
    int          n_total = 0;

    // Count the cycles each strobe is high, sampled away from the active edge.
    always @(negedge ACLK) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_wr_pulse_o[k] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic int pulse_total();
        int s = 0;
        for (int k = 0; k < NUM_REGS; k++) s += pulse_cnt[k];
        return s;
    endfunction

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = model[k];
        return f;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_bus();
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0;  s_axi.wstrb = '0;  s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
    endtask

    // Full write transaction with BREADY held high. Returns BRESP and whether it timed out.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output logic tmo);
        logic aw_f, w_f, b_f, got_b;
        s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
        s_axi.wdata = data;  s_axi.wstrb = strb; s_axi.wvalid = 1'b1;
        s_axi.bready = 1'b1;
        got_b = 1'b0;
        resp = 2'bxx;
        for (int c = 0; c < BUDGET && !got_b; c++) begin
            aw_f = s_axi.awvalid && s_axi.awready;
            w_f  = s_axi.wvalid && s_axi.wready;
            b_f  = s_axi.bvalid && s_axi.bready;
            if (b_f) resp = s_axi.bresp;
            tick();
            if (aw_f) s_axi.awvalid = 1'b0;
            if (w_f)  s_axi.wvalid = 1'b0;
            if (b_f)  got_b = 1'b1;
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        tmo = !got_b;
    endtask

    // Full read transaction with RREADY held high.
    task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic tmo);
        logic ar_f, r_f, got_r;
        s_axi.araddr = addr; s_axi.arvalid = 1'b1; s_axi.rready = 1'b1;
        got_r = 1'b0;
        data = 'x;
        resp = 2'bxx;
        for (int c = 0; c < BUDGET && !got_r; c++) begin
            ar_f = s_axi.arvalid && s_axi.arready;
            r_f  = s_axi.rvalid && s_axi.rready;
            if (r_f) begin
                data = s_axi.rdata;
                resp = s_axi.rresp;
            end
            tick();
            if (ar_f) s_axi.arvalid = 1'b0;
            if (r_f)  got_r = 1'b1;
        end
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        tmo = !got_r;
    endtask

    task automatic test_reset();
        idle_bus();
        ARESET = 1'b1;
        repeat (3) tick();
        n_total++;
        if (regs_o !== '0) $display("FAIL reset_regs: got %h want 0", regs_o);
        else n_pass++;
        n_total++;
        if ({s_axi.bvalid, s_axi.rvalid, s_axi.awready, s_axi.wready, s_axi.arready, reg_wr_pulse_o} !== '0)
            $display("FAIL reset_ctrl: got bv=%b rv=%b awr=%b wr=%b arr=%b pulse=%b want all 0",
                     s_axi.bvalid, s_axi.rvalid, s_axi.awready, s_axi.wready, s_axi.arready, reg_wr_pulse_o);
        else n_pass++;
        n_total++;
        if ({s_axi.rdata, s_axi.rresp, s_axi.bresp} !== '0)
            $display("FAIL reset_resp: got rdata=%h rresp=%b bresp=%b want 0", s_axi.rdata, s_axi.rresp, s_axi.bresp);
        else n_pass++;
        ARESET = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        tick();
        n_total++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111)
            $display("FAIL reset_release_ready: got %b want 111", {s_axi.awready, s_axi.wready, s_axi.arready});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [31:0] d; logic tmo; exp_t e;
        int pc0 [NUM_REGS];
        pc0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            model[i] = 32'(i + 1);
            exp_q.push_back('{data: 32'h0, resp: OKAY});
            do_write(ADDR_W'(i * 4), 32'(i + 1), 4'hF, r, tmo);
            e = exp_q.pop_front();
            n_total++;
            if (tmo || r !== e.resp) $display("FAIL basic_bresp_%0d: got %b tmo=%0b want %b", i, r, tmo, e.resp);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: model[i], resp: OKAY});
            do_read(ADDR_W'(i * 4), d, r, tmo);
            e = exp_q.pop_front();
            n_total++;
            if (tmo || d !== e.data || r !== e.resp)
                $display("FAIL basic_read_%0d: got %h/%b tmo=%0b want %h/%b", i, d, r, tmo, e.data, e.resp);
            else n_pass++;
        end
        n_total++;
        if (regs_o !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL basic_regs_o: got %h want 4,3,2,1", regs_o);
        else n_pass++;
        for (int k = 0; k < NUM_REGS; k++) begin
            n_total++;
            if (pulse_cnt[k] - pc0[k] !== 1)
                $display("FAIL basic_pulse_%0d: got %0d want 1", k, pulse_cnt[k] - pc0[k]);
            else n_pass++;
        end
    endtask

    task automatic test_w_before_aw();
        int pc0 [NUM_REGS];
        int p_tot0, bad;
        pc0 = pulse_cnt;
        p_tot0 = pulse_total();
        s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        n_total++;
        if (s_axi.wready !== 1'b0) $display("FAIL wfirst_wready_held: got %b want 0", s_axi.wready);
        else n_pass++;
        repeat (3) tick();
        s_axi.awaddr = 5'h0C; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        model[3] = 32'hDEADBEEF;
        n_total++;
        if ({s_axi.bvalid, s_axi.awready} !== 2'b00)
            $display("FAIL wfirst_pre_commit: got bvalid=%b awready=%b want 0 0", s_axi.bvalid, s_axi.awready);
        else n_pass++;
        tick();
        n_total++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== OKAY)
            $display("FAIL wfirst_latency: got bvalid=%b bresp=%b want 1 00", s_axi.bvalid, s_axi.bresp);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!(s_axi.bvalid === 1'b1 && s_axi.bresp === OKAY && s_axi.awready === 1'b0 && s_axi.wready === 1'b0))
                bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL wfirst_b_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        n_total++;
        if ({s_axi.bvalid, s_axi.awready, s_axi.wready} !== 3'b011)
            $display("FAIL wfirst_after_b: got bv/awr/wr=%b want 011", {s_axi.bvalid, s_axi.awready, s_axi.wready});
        else n_pass++;
        n_total++;
        if (pulse_cnt[3] - pc0[3] !== 1 || pulse_total() - p_tot0 !== 1)
            $display("FAIL wfirst_pulse: got reg3=%0d total=%0d want 1 1", pulse_cnt[3] - pc0[3], pulse_total() - p_tot0);
        else n_pass++;
        n_total++;
        if (regs_o !== model_flat()) $display("FAIL wfirst_regs_o: got %h want %h", regs_o, model_flat());
        else n_pass++;
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d; logic tmo; exp_t e;
        do_write(5'h08, 32'h11223344, 4'hF, r, tmo);
        model[2] = 32'h11223344;
        do_write(5'h08, 32'hAABBCCDD, 4'b0101, r, tmo);
        model[2] = merge(model[2], 32'hAABBCCDD, 4'b0101);
        exp_q.push_back('{data: 32'h11BB33DD, resp: OKAY});
        do_read(5'h08, d, r, tmo);
        e = exp_q.pop_front();
        n_total++;
        if (tmo || d !== e.data || r !== e.resp)
            $display("FAIL strobe_read: got %h/%b tmo=%0b want %h/%b", d, r, tmo, e.data, e.resp);
        else n_pass++;
        n_total++;
        if (regs_o !== model_flat()) $display("FAIL strobe_regs_o: got %h want %h", regs_o, model_flat());
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [1:0] r; logic [31:0] d; logic tmo; exp_t e;
        int p_tot0;
        logic [4:0] raddr [3];
        raddr = '{5'h14, 5'h1F, 5'h07};
        p_tot0 = pulse_total();
        exp_q.push_back('{data: 32'h0, resp: SLVERR});
        do_write(5'h10, 32'hFFFFFFFF, 4'hF, r, tmo);
        e = exp_q.pop_front();
        n_total++;
        if (tmo || r !== e.resp) $display("FAIL decode_wr_slverr: got %b tmo=%0b want %b", r, tmo, e.resp);
        else n_pass++;
        n_total++;
        if (regs_o !== model_flat() || pulse_total() !== p_tot0)
            $display("FAIL decode_wr_side_effect: got regs=%h pulses=%0d want regs=%h pulses=%0d",
                     regs_o, pulse_total() - p_tot0, model_flat(), 0);
        else n_pass++;
        exp_q.push_back('{data: 32'h0, resp: SLVERR});
        exp_q.push_back('{data: 32'h0, resp: SLVERR});
        exp_q.push_back('{data: model[1], resp: OKAY});
        for (int i = 0; i < 3; i++) begin
            do_read(raddr[i], d, r, tmo);
            e = exp_q.pop_front();
            n_total++;
            if (tmo || d !== e.data || r !== e.resp)
                $display("FAIL decode_read_%h: got %h/%b tmo=%0b want %h/%b", raddr[i], d, r, tmo, e.data, e.resp);
            else n_pass++;
        end
    endtask

    task automatic test_same_edge();
        logic [1:0] r; logic [31:0] d; logic tmo; exp_t e;
        do_write(5'h04, 32'h5, 4'hF, r, tmo);
        model[1] = 32'h5;
        s_axi.awaddr = 5'h04; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h9; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.araddr = 5'h04; s_axi.arvalid = 1'b1;
        exp_q.push_back('{data: model[1], resp: OKAY});
        tick();
        s_axi.arvalid = 1'b0;
        model[1] = 32'h9;
        e = exp_q.pop_front();
        n_total++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== e.data || s_axi.rresp !== e.resp)
            $display("FAIL same_edge_old_value: got rv=%b %h/%b want 1 %h/%b",
                     s_axi.rvalid, s_axi.rdata, s_axi.rresp, e.data, e.resp);
        else n_pass++;
        n_total++;
        if (s_axi.bvalid !== 1'b1) $display("FAIL same_edge_commit: got bvalid=%b want 1", s_axi.bvalid);
        else n_pass++;
        s_axi.rready = 1'b1; s_axi.bready = 1'b1;
        tick();
        s_axi.rready = 1'b0; s_axi.bready = 1'b0;
        exp_q.push_back('{data: model[1], resp: OKAY});
        do_read(5'h04, d, r, tmo);
        e = exp_q.pop_front();
        n_total++;
        if (tmo || d !== e.data || r !== e.resp)
            $display("FAIL same_edge_new_value: got %h/%b tmo=%0b want %h/%b", d, r, tmo, e.data, e.resp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [31:0] d; logic tmo; exp_t e;
        int bad;
        s_axi.awaddr = 5'h04; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h77; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        s_axi.wdata = 32'h88;
        tick();
        #3;
        ARESET = 1'b1;
        #1;
        n_total++;
        if (s_axi.bvalid !== 1'b0 || regs_o !== '0 || s_axi.wready !== 1'b0)
            $display("FAIL midreset_async: got bvalid=%b regs=%h wready=%b want 0 0 0", s_axi.bvalid, regs_o, s_axi.wready);
        else n_pass++;
        s_axi.wvalid = 1'b0;
        tick();
        ARESET = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        tick();
        // Capture a W beat, reset, then send only an AW: the stale W must not commit.
        s_axi.wdata = 32'hBAD0BAD0; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        s_axi.awaddr = 5'h00; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_axi.bvalid !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0 || regs_o !== '0)
            $display("FAIL midreset_stale_w: got %0d bvalid cycles regs=%h want 0 0", bad, regs_o);
        else n_pass++;
        s_axi.wdata = 32'hCAFEF00D; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        model[0] = 32'hCAFEF00D;
        exp_q.push_back('{data: 32'h0, resp: OKAY});
        tick();
        e = exp_q.pop_front();
        n_total++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== e.resp)
            $display("FAIL midreset_fresh_write: got bvalid=%b bresp=%b want 1 %b", s_axi.bvalid, s_axi.bresp, e.resp);
        else n_pass++;
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        exp_q.push_back('{data: model[0], resp: OKAY});
        do_read(5'h00, d, r, tmo);
        e = exp_q.pop_front();
        n_total++;
        if (tmo || d !== e.data || r !== e.resp || regs_o !== model_flat())
            $display("FAIL midreset_readback: got %h/%b tmo=%0b regs=%h want %h/%b regs=%h",
                     d, r, tmo, regs_o, e.data, e.resp, model_flat());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_decode();
        test_same_edge();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
